// File: rtl/mprj_stim_pkg.sv
// Shared definitions for the stimulus generator: register map, mode and
// status encodings, sequencer state type and the LFSR feedback polynomial.
package mprj_stim_pkg;

    localparam logic [7:0] OFF_CTRL    = 8'h00;
    localparam logic [7:0] OFF_PATTERN = 8'h04;
    localparam logic [7:0] OFF_DIV     = 8'h08;
    localparam logic [7:0] OFF_STEPS   = 8'h0C;
    localparam logic [7:0] OFF_CAPTURE = 8'h10;
    localparam logic [7:0] OFF_STATE   = 8'h14;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_INC  = 2'd1,
        MODE_LFSR = 2'd2,
        MODE_CAPT = 2'd3
    } mode_e;

    localparam logic [3:0] STATUS_IDLE = 4'h0;
    localparam logic [3:0] STATUS_RUN  = 4'hA;
    localparam logic [3:0] STATUS_DONE = 4'h5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/mprj_stim_if.sv
// Wishbone slave bundle used between the harness bus and the generator.
interface mprj_stim_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

endinterface

// File: rtl/mprj_stim_regs.sv
// Wishbone register file for the stimulus generator: control/config
// registers, read mux, single-cycle ack and the io_in capture synchronizer.
module mprj_stim_regs
    import mprj_stim_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        clock,
    input  logic        resetb,
    mprj_stim_if.slave  wbs,
    input  logic [3:0]  status,
    input  logic [15:0] io_in_lo,
    output logic        ctrl_en,
    output mode_e       ctrl_mode,
    output logic        ctrl_stop,
    output logic [15:0] pattern,
    output logic [15:0] div,
    output logic [15:0] steps,
    output logic [15:0] capture
);

    logic        req;
    logic        acc;
    logic        wr;
    logic [7:0]  off;
    logic        ack_q;
    logic [31:0] dat_q;
    logic [31:0] rdata;
    logic [15:0] capt_p0;
    logic [15:0] capt_p1;
    logic        unused_bits;

    // A request is taken only when no ack is outstanding, so acks never
    // land on back-to-back cycles even if the master holds stb.
    assign req  = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign acc  = req & ~ack_q;
    assign wr   = acc & wbs.wbs_we_i;
    assign off  = wbs.wbs_adr_i[7:0];

    // Combinational so the sequencer can drop out of RUN on the very edge
    // the disabling write lands, ahead of any step due on that edge.
    assign ctrl_stop = wr & (off == OFF_CTRL) & wbs.wbs_sel_i[0] & ~wbs.wbs_dat_i[0];

    assign unused_bits   = ^{wbs.wbs_dat_i[31:16], wbs.wbs_sel_i[3:2]};
    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign capture       = capt_p1;

    function automatic logic [15:0] merge16(input logic [15:0] cur,
                                            input logic [15:0] wdat,
                                            input logic [1:0]  be);
        merge16 = cur;
        if (be[0]) merge16[7:0]  = wdat[7:0];
        if (be[1]) merge16[15:8] = wdat[15:8];
    endfunction

    // Read mux; unmapped offsets return zero
    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL:    rdata = {29'd0, ctrl_mode, ctrl_en};
            OFF_PATTERN: rdata = {16'd0, pattern};
            OFF_DIV:     rdata = {16'd0, div};
            OFF_STEPS:   rdata = {16'd0, steps};
            OFF_CAPTURE: rdata = {16'd0, capt_p1};
            OFF_STATE:   rdata = {28'd0, status};
            default:     rdata = '0;
        endcase
    end

    // Bus response and byte-enabled register writes
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            ctrl_en   <= 1'b0;
            ctrl_mode <= MODE_HOLD;
            pattern   <= '0;
            div       <= '0;
            steps     <= '0;
        end else begin
            ack_q <= acc;
            dat_q <= acc ? rdata : '0;
            if (wr) begin
                case (off)
                    OFF_CTRL: begin
                        if (wbs.wbs_sel_i[0]) begin
                            ctrl_en   <= wbs.wbs_dat_i[0];
                            ctrl_mode <= mode_e'(wbs.wbs_dat_i[2:1]);
                        end
                    end
                    OFF_PATTERN: pattern <= merge16(pattern, wbs.wbs_dat_i[15:0], wbs.wbs_sel_i[1:0]);
                    OFF_DIV:     div     <= merge16(div,     wbs.wbs_dat_i[15:0], wbs.wbs_sel_i[1:0]);
                    OFF_STEPS:   steps   <= merge16(steps,   wbs.wbs_dat_i[15:0], wbs.wbs_sel_i[1:0]);
                    default: ;
                endcase
            end
        end
    end

    // Two-flop synchronizer bringing io_in[15:0] into the clock domain
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            capt_p0 <= '0;
            capt_p1 <= '0;
        end else begin
            capt_p0 <= io_in_lo;
            capt_p1 <= capt_p0;
        end
    end

endmodule

// File: rtl/mprj_stim_gen.sv
// Pattern/stimulus generator for the user project area: a Wishbone-programmed
// sequencer that steps a 16-bit data word (hold, count, LFSR or captured
// input) at a programmable rate and drives it onto the user I/O pads.
module mprj_stim_gen
    import mprj_stim_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter logic [15:0] LFSR_SEED_DFLT = 16'hACE1
) (
    input  logic        clock,
    input  logic        resetb,
    mprj_stim_if.slave  wbs,
    input  logic [37:0] io_in,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb
);

    logic        ctrl_en;
    mode_e       ctrl_mode;
    logic        ctrl_stop;
    logic [15:0] pattern;
    logic [15:0] div;
    logic [15:0] steps;
    logic [15:0] capture;

    state_e      state;
    logic [3:0]  status_q;
    logic [15:0] data_q;
    logic [15:0] presc_q;
    logic [15:0] step_cnt_q;
    logic        en_q;
    logic        unused_io;

    assign unused_io = ^io_in[37:16];

    mprj_stim_regs #(
        .BASE_ADDR (BASE_ADDR)
    ) u_regs (
        .clock     (clock),
        .resetb    (resetb),
        .wbs       (wbs),
        .status    (status_q),
        .io_in_lo  (io_in[15:0]),
        .ctrl_en   (ctrl_en),
        .ctrl_mode (ctrl_mode),
        .ctrl_stop (ctrl_stop),
        .pattern   (pattern),
        .div       (div),
        .steps     (steps),
        .capture   (capture)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        lfsr_next = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    function automatic logic [15:0] step_value(input mode_e       m,
                                               input logic [15:0] cur,
                                               input logic [15:0] capt);
        case (m)
            MODE_INC:  step_value = cur + 16'd1;
            MODE_LFSR: step_value = lfsr_next(cur);
            MODE_CAPT: step_value = capt;
            default:   step_value = cur;
        endcase
    endfunction

    // Sequencer: start on enable rising, step on prescaler wrap, stop on
    // step count; a disable always wins and leaves data where it was.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state      <= ST_IDLE;
            status_q   <= STATUS_IDLE;
            data_q     <= '0;
            presc_q    <= '0;
            step_cnt_q <= '0;
            en_q       <= 1'b0;
        end else begin
            en_q <= ctrl_en;
            if (ctrl_stop || !ctrl_en) begin
                state    <= ST_IDLE;
                status_q <= STATUS_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!en_q) begin
                            state      <= ST_RUN;
                            status_q   <= STATUS_RUN;
                            presc_q    <= '0;
                            step_cnt_q <= '0;
                            data_q     <= (ctrl_mode == MODE_LFSR && pattern == 16'h0000)
                                          ? LFSR_SEED_DFLT : pattern;
                        end
                    end
                    ST_RUN: begin
                        if (presc_q == div) begin
                            presc_q    <= '0;
                            data_q     <= step_value(ctrl_mode, data_q, capture);
                            step_cnt_q <= step_cnt_q + 16'd1;
                            if (steps != 16'h0000 && (step_cnt_q + 16'd1) == steps) begin
                                state    <= ST_DONE;
                                status_q <= STATUS_DONE;
                            end
                        end else begin
                            presc_q <= presc_q + 16'd1;
                        end
                    end
                    ST_DONE: ;
                    default: begin
                        state    <= ST_IDLE;
                        status_q <= STATUS_IDLE;
                    end
                endcase
            end
        end
    end

    assign io_out = {status_q, 2'b00, data_q, 16'h0000};
    assign io_oeb = {4'b0000, 2'b11, 16'h0000, 16'hFFFF};

endmodule

// File: tb/tb_mprj_stim_gen.sv
// Directed bench for mprj_stim_gen with a queue-based scoreboard.
module tb_mprj_stim_gen;
    import mprj_stim_pkg::*;

    localparam logic [31:0] BASE    = 32'h3000_0000;
    localparam logic [37:0] OEB_EXP = 38'h03_0000_FFFF;

    logic        clock  = 1'b0;
    logic        resetb = 1'b0;
    logic [37:0] io_in;
    logic [37:0] io_out;
    logic [37:0] io_oeb;

    mprj_stim_if wbs ();

    mprj_stim_gen dut (
        .clock  (clock),
        .resetb (resetb),
        .wbs    (wbs),
        .io_in  (io_in),
        .io_out (io_out),
        .io_oeb (io_oeb)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    string       tag_q[$];
    logic [31:0] rd;

    task automatic sb_push(input string tag, input logic [63:0] exp_v);
        exp_q.push_back(exp_v);
        tag_q.push_back(tag);
    endtask

    task automatic sb_check(input logic [63:0] obs);
        logic [63:0] e;
        string       t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=%0h expected=<none>", obs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wb_req(input logic [7:0] off, input logic we, input logic [31:0] dat,
                          input logic [3:0] sel);
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        wbs.wbs_we_i  = we;
        wbs.wbs_adr_i = BASE | {24'h0, off};
        wbs.wbs_dat_i = dat;
        wbs.wbs_sel_i = sel;
    endtask

    task automatic wb_idle();
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_we_i  = 1'b0;
    endtask

    task automatic wb_wait_ack();
        int n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        while (n < 16) begin
            tick(1);
            n++;
            if (wbs.wbs_ack_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $error("FAIL ack_timeout observed=0 expected=1 adr=%0h", wbs.wbs_adr_i);
        end
    endtask

    task automatic wb_write(input logic [7:0] off, input logic [31:0] dat, input logic [3:0] sel);
        wb_req(off, 1'b1, dat, sel);
        wb_wait_ack();
        wb_idle();
    endtask

    task automatic wb_read(input logic [7:0] off, output logic [31:0] d);
        wb_req(off, 1'b0, 32'h0, 4'hF);
        wb_wait_ack();
        d = wbs.wbs_dat_o;
        wb_idle();
    endtask

    // Holds stb one extra cycle after the ack to show the ack does not repeat
    task automatic wb_read_hold(input logic [7:0] off, output logic [31:0] d);
        wb_req(off, 1'b0, 32'h0, 4'hF);
        wb_wait_ack();
        d = wbs.wbs_dat_o;
        sb_push("ack_single_cycle", 64'h0);
        tick(1);
        sb_check(64'(wbs.wbs_ack_o));
        wb_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        io_in         = '0;
        wbs.wbs_adr_i = '0;
        wbs.wbs_dat_i = '0;
        wbs.wbs_sel_i = '0;
        wb_idle();

        // Reset state
        #13;
        sb_push("rst_io_out", 64'h0);
        sb_push("rst_io_oeb", 64'(OEB_EXP));
        sb_push("rst_ack", 64'h0);
        sb_push("rst_dat_o", 64'h0);
        sb_check(64'(io_out));
        sb_check(64'(io_oeb));
        sb_check(64'(wbs.wbs_ack_o));
        sb_check(64'(wbs.wbs_dat_o));
        #4 resetb = 1'b1;
        tick(1);

        // Byte-select writes and unmapped offsets
        wb_write(OFF_PATTERN, 32'h0000_FFFF, 4'b0011);
        wb_write(OFF_PATTERN, 32'h0000_1234, 4'b0010);
        sb_push("pattern_bytesel", 64'h12FF);
        wb_read(OFF_PATTERN, rd);
        sb_check(64'(rd));
        wb_write(8'h40, 32'hFFFF_FFFF, 4'hF);
        sb_push("unmapped_read", 64'h0);
        wb_read_hold(8'h40, rd);
        sb_check(64'(rd));

        // Mode 0 hold
        wb_write(OFF_PATTERN, 32'h0000_AB40, 4'hF);
        wb_write(OFF_DIV,     32'h0, 4'hF);
        wb_write(OFF_STEPS,   32'h0, 4'hF);
        sb_push("m0_data", 64'hAB40);
        sb_push("m0_status", 64'hA);
        sb_push("m0_data_hold", 64'hAB40);
        wb_write(OFF_CTRL, 32'h1, 4'hF);
        tick(1);
        sb_check(64'(io_out[31:16]));
        sb_check(64'(io_out[37:34]));
        tick(3);
        sb_check(64'(io_out[31:16]));
        sb_push("m0_state_reg", 64'hA);
        wb_read(OFF_STATE, rd);
        sb_check(64'(rd));
        sb_push("m0_disable_status", 64'h0);
        wb_write(OFF_CTRL, 32'h0, 4'hF);
        tick(1);
        sb_check(64'(io_out[37:34]));

        // Mode 1 increment with wrap, DIV=3, STEPS=3
        wb_write(OFF_PATTERN, 32'h0000_FFFE, 4'hF);
        wb_write(OFF_DIV,     32'h3, 4'hF);
        wb_write(OFF_STEPS,   32'h3, 4'hF);
        sb_push("m1_load", 64'hFFFE);
        sb_push("m1_before_step", 64'hFFFE);
        sb_push("m1_step1", 64'hFFFF);
        sb_push("m1_step2", 64'h0000);
        sb_push("m1_step3", 64'h0001);
        sb_push("m1_done_status", 64'h5);
        sb_push("m1_frozen", 64'h0001);
        sb_push("m1_frozen_status", 64'h5);
        wb_write(OFF_CTRL, 32'h3, 4'hF);
        tick(1);
        sb_check(64'(io_out[31:16]));
        tick(3);
        sb_check(64'(io_out[31:16]));
        tick(1);
        sb_check(64'(io_out[31:16]));
        tick(4);
        sb_check(64'(io_out[31:16]));
        tick(4);
        sb_check(64'(io_out[31:16]));
        sb_check(64'(io_out[37:34]));
        tick(8);
        sb_check(64'(io_out[31:16]));
        sb_check(64'(io_out[37:34]));
        wb_write(OFF_CTRL, 32'h0, 4'hF);

        // Mode 2 LFSR from zero pattern; ACE1 -> E270 -> 7138
        wb_write(OFF_PATTERN, 32'h0, 4'hF);
        wb_write(OFF_DIV,     32'h0, 4'hF);
        wb_write(OFF_STEPS,   32'h2, 4'hF);
        sb_push("m2_seed", 64'hACE1);
        sb_push("m2_run_status", 64'hA);
        sb_push("m2_step1", 64'hE270);
        sb_push("m2_step2", 64'h7138);
        sb_push("m2_done_status", 64'h5);
        wb_write(OFF_CTRL, 32'h5, 4'hF);
        tick(1);
        sb_check(64'(io_out[31:16]));
        sb_check(64'(io_out[37:34]));
        tick(1);
        sb_check(64'(io_out[31:16]));
        tick(1);
        sb_check(64'(io_out[31:16]));
        sb_check(64'(io_out[37:34]));
        wb_write(OFF_CTRL, 32'h0, 4'hF);

        // Mode 3 capture
        io_in = 38'h2A_5A5A_0009;
        wb_write(OFF_PATTERN, 32'h0000_1111, 4'hF);
        wb_write(OFF_STEPS,   32'h0, 4'hF);
        sb_push("m3_data", 64'h0009);
        sb_push("m3_other_bits", 64'h0);
        sb_push("m3_capture_reg", 64'h0009);
        wb_write(OFF_CTRL, 32'h7, 4'hF);
        tick(2);
        sb_check(64'(io_out[31:16]));
        sb_check(64'({io_out[33:32], io_out[15:0]}));
        wb_read(OFF_CAPTURE, rd);
        sb_check(64'(rd));
        wb_write(OFF_CTRL, 32'h0, 4'hF);

        // Disable lands on the edge a step is due
        wb_write(OFF_PATTERN, 32'h0000_1000, 4'hF);
        wb_write(OFF_DIV,     32'h3, 4'hF);
        sb_push("dis_before", 64'h1001);
        sb_push("dis_data", 64'h1001);
        sb_push("dis_status", 64'h0);
        sb_push("dis_data_held", 64'h1001);
        wb_write(OFF_CTRL, 32'h3, 4'hF);
        tick(8);
        sb_check(64'(io_out[31:16]));
        wb_write(OFF_CTRL, 32'h0, 4'hF);
        sb_check(64'(io_out[31:16]));
        sb_check(64'(io_out[37:34]));
        tick(3);
        sb_check(64'(io_out[31:16]));
        sb_push("dis_unmapped_read", 64'h0);
        wb_read_hold(8'h40, rd);
        sb_check(64'(rd));

        // Asynchronous reset mid-run with an ack in flight
        wb_write(OFF_DIV, 32'h0, 4'hF);
        wb_write(OFF_CTRL, 32'h3, 4'hF);
        tick(3);
        sb_push("ar_ack_before", 64'h1);
        sb_push("ar_io_out", 64'h0);
        sb_push("ar_ack", 64'h0);
        sb_push("ar_dat_o", 64'h0);
        sb_push("ar_io_oeb", 64'(OEB_EXP));
        wb_req(OFF_STATE, 1'b0, 32'h0, 4'hF);
        @(posedge clock);
        #2;
        sb_check(64'(wbs.wbs_ack_o));
        resetb = 1'b0;
        #1;
        sb_check(64'(io_out));
        sb_check(64'(wbs.wbs_ack_o));
        sb_check(64'(wbs.wbs_dat_o));
        sb_check(64'(io_oeb));
        wb_idle();
        #3 resetb = 1'b1;
        tick(2);
        sb_push("ar_status_after", 64'h0);
        sb_push("ar_state_reg", 64'h0);
        sb_push("ar_ctrl_reg", 64'h0);
        sb_check(64'(io_out[37:34]));
        wb_read(OFF_STATE, rd);
        sb_check(64'(rd));
        wb_read(OFF_CTRL, rd);
        sb_check(64'(rd));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
